// File: rtl/nn_pkg.sv
// Shared types for the NN training sequencer: FSM state encoding and strobe bit positions.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRT,
    T_ISS,
    T_WAIT,
    V_ISS,
    V_WAIT,
    STORE,
    FIN
  } state_t;

  localparam int unsigned STB_START = 0;
  localparam int unsigned STB_TR    = 1;
  localparam int unsigned STB_VL    = 2;
  localparam int unsigned STB_SW    = 3;
  localparam int unsigned STB_END   = 4;
  localparam int unsigned NUM_STB   = 5;

  // First phase of an epoch: training if any, else validation if any, else straight to store.
  function automatic state_t epoch_entry(input logic train_nz, input logic valid_nz);
    state_t s;
    if (train_nz)      s = T_ISS;
    else if (valid_nz) s = V_ISS;
    else               s = STORE;
    return s;
  endfunction

endpackage

// File: rtl/nn_sequencer.sv
// Epoch/sample sequencer: issues train and validation strobes to the pattern block,
// waits on the architecture block, and accumulates validation accuracy per epoch.
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [BITS-1:0] TRAIN,
  input  logic [BITS-1:0] VALID,
  input  logic [BITS-1:0] EPOCH,
  input  logic            arch_done,
  input  logic            arch_correct,
  output logic            START,
  output logic            TR,
  output logic            VL,
  output logic            SW,
  output logic            END,
  output logic            busy,
  output logic [BITS-1:0] epoch_cnt,
  output logic [BITS-1:0] val_correct
);

  state_t               state, state_n;
  logic [BITS-1:0]      sample_cnt, sample_cnt_n;
  logic [BITS-1:0]      acc, acc_n;
  logic [BITS-1:0]      epoch_q, epoch_n;
  logic [BITS-1:0]      valc_q, valc_n;
  logic [BITS-1:0]      epoch_inc;
  logic [NUM_STB-1:0]   stb_q, stb_n;
  logic                 busy_q, busy_n;

  // State and all outputs registered; strobes decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      acc        <= '0;
      epoch_q    <= '0;
      valc_q     <= '0;
      stb_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_cnt_n;
      acc        <= acc_n;
      epoch_q    <= epoch_n;
      valc_q     <= valc_n;
      stb_q      <= stb_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    sample_cnt_n = sample_cnt;
    acc_n        = acc;
    epoch_n      = epoch_q;
    valc_n       = valc_q;
    epoch_inc    = epoch_q + BITS'(1);
    stb_n        = '0;
    busy_n       = 1'b0;

    case (state)
      IDLE: begin
        if (go) state_n = STRT;
      end
      STRT: begin
        sample_cnt_n = '0;
        epoch_n      = '0;
        acc_n        = '0;
        valc_n       = '0;
        if (EPOCH == '0) state_n = FIN;
        else             state_n = epoch_entry(TRAIN != '0, VALID != '0);
      end
      T_ISS: begin
        sample_cnt_n = sample_cnt + BITS'(1);
        state_n      = T_WAIT;
      end
      T_WAIT: begin
        if (arch_done) begin
          if (sample_cnt < TRAIN) begin
            state_n = T_ISS;
          end else begin
            sample_cnt_n = '0;
            if (VALID != '0) state_n = V_ISS;
            else             state_n = STORE;
          end
        end
      end
      V_ISS: begin
        sample_cnt_n = sample_cnt + BITS'(1);
        state_n      = V_WAIT;
      end
      V_WAIT: begin
        if (arch_done) begin
          // Saturating accumulate so very long validation sets never wrap.
          if (arch_correct && (acc != '1)) acc_n = acc + BITS'(1);
          if (sample_cnt < VALID) begin
            state_n = V_ISS;
          end else begin
            sample_cnt_n = '0;
            state_n      = STORE;
          end
        end
      end
      STORE: begin
        valc_n  = acc;
        acc_n   = '0;
        epoch_n = epoch_inc;
        if (epoch_inc == EPOCH) state_n = FIN;
        else                    state_n = epoch_entry(TRAIN != '0, VALID != '0);
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // One-hot strobe per issuing state, visible while the FSM sits in it.
    case (state_n)
      STRT:    stb_n[STB_START] = 1'b1;
      T_ISS:   stb_n[STB_TR]    = 1'b1;
      V_ISS:   stb_n[STB_VL]    = 1'b1;
      STORE:   stb_n[STB_SW]    = 1'b1;
      FIN:     stb_n[STB_END]   = 1'b1;
      default: stb_n            = '0;
    endcase
    busy_n = (state_n != IDLE);
  end

  assign START       = stb_q[STB_START];
  assign TR          = stb_q[STB_TR];
  assign VL          = stb_q[STB_VL];
  assign SW          = stb_q[STB_SW];
  assign END         = stb_q[STB_END];
  assign busy        = busy_q;
  assign epoch_cnt   = epoch_q;
  assign val_correct = valc_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed scoreboard bench for nn_sequencer: expected strobe order is queued per run
// and popped as strobes appear; a built-in responder answers each TR/VL with arch_done.
module tb_nn_sequencer;

  localparam logic [4:0] C_S = 5'b00001;
  localparam logic [4:0] C_T = 5'b00010;
  localparam logic [4:0] C_V = 5'b00100;
  localparam logic [4:0] C_W = 5'b01000;
  localparam logic [4:0] C_E = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go16, go4, arch_done, arch_correct;
  logic [15:0] train16, valid16, epoch16;
  logic [3:0]  train4, valid4, epoch4;
  logic        st16, tr16, vl16, sw16, en16, busy16;
  logic        st4, tr4, vl4, sw4, en4, busy4;
  logic [15:0] epc16, valc16;
  logic [3:0]  epc4, valc4;

  nn_sequencer #(.BITS(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16),
    .TRAIN(train16), .VALID(valid16), .EPOCH(epoch16),
    .arch_done(arch_done), .arch_correct(arch_correct),
    .START(st16), .TR(tr16), .VL(vl16), .SW(sw16), .END(en16),
    .busy(busy16), .epoch_cnt(epc16), .val_correct(valc16)
  );

  nn_sequencer #(.BITS(4)) dut4 (
    .clk(clk), .rst(rst), .go(go4),
    .TRAIN(train4), .VALID(valid4), .EPOCH(epoch4),
    .arch_done(arch_done), .arch_correct(arch_correct),
    .START(st4), .TR(tr4), .VL(vl4), .SW(sw4), .END(en4),
    .busy(busy4), .epoch_cnt(epc4), .val_correct(valc4)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [4:0]  exp_q[$];
  int          cyc = 0, cd = 0, val_idx = 0, start_cyc = 0, end_cyc = 0;
  logic        saw_end = 1'b0, spur_tiss = 1'b0, sel4 = 1'b0, cur_correct = 1'b0;
  logic [15:0] mask = '0;
  logic [4:0]  last_obs = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    if (sel4) return {en4, sw4, vl4, tr4, st4};
    return {en16, sw16, vl16, tr16, st16};
  endfunction

  task automatic push(input logic [4:0] c, input int n);
    repeat (n) exp_q.push_back(c);
  endtask

  // One clock: sample after the edge, score any strobe, drive the arch responder.
  task automatic tick();
    logic [4:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    arch_done    = 1'b0;
    arch_correct = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        arch_done    = 1'b1;
        arch_correct = cur_correct;
      end
    end
    obs      = strobes();
    last_obs = obs;
    if (obs != '0) begin
      check("strobe_onehot", 32'($countones(obs)), 32'd1);
      if (exp_q.size() == 0) check("unexpected_strobe", 32'(obs), 32'd0);
      else                   check("strobe_order", 32'(obs), 32'(exp_q.pop_front()));
    end
    case (obs)
      C_S: begin start_cyc = cyc; val_idx = 0; end
      C_T: begin
        cd = 2;
        if (spur_tiss) begin arch_done = 1'b1; arch_correct = 1'b1; end
      end
      C_V: begin cd = 2; cur_correct = mask[val_idx]; val_idx++; end
      C_W: val_idx = 0;
      C_E: begin end_cyc = cyc; saw_end = 1'b1; go16 = 1'b0; go4 = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic run(input logic use4, input logic hold, input int budget);
    int n;
    sel4    = use4;
    saw_end = 1'b0;
    if (use4) go4 = 1'b1;
    else      go16 = 1'b1;
    tick();
    n = 1;
    if (!hold) begin go4 = 1'b0; go16 = 1'b0; end
    check("busy_in_run", 32'(use4 ? busy4 : busy16), 32'd1);
    while (!saw_end && n < budget) begin
      tick();
      n++;
    end
    check("run_completed", 32'(saw_end), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    tick();
    check("busy_after_run", 32'(use4 ? busy4 : busy16), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; go16 = 1'b0; go4 = 1'b0; arch_done = 1'b0; arch_correct = 1'b0;
    train16 = '0; valid16 = '0; epoch16 = '0;
    train4 = '0; valid4 = '0; epoch4 = '0;

    // Reset state
    tick();
    tick();
    check("rst_strobes16", 32'({en16, sw16, vl16, tr16, st16}), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_epoch16", 32'(epc16), 32'd0);
    check("rst_valc16", 32'(valc16), 32'd0);
    check("rst_strobes4", 32'({en4, sw4, vl4, tr4, st4}), 32'd0);
    rst = 1'b0;
    tick();

    // Basic run: 3 train, 2 validation (second correct), 1 epoch
    train16 = 16'd3; valid16 = 16'd2; epoch16 = 16'd1; mask = 16'b10;
    push(C_S, 1); push(C_T, 3); push(C_V, 2); push(C_W, 1); push(C_E, 1);
    run(1'b0, 1'b0, 200);
    check("t1_val_correct", 32'(valc16), 32'd1);
    check("t1_epoch_cnt", 32'(epc16), 32'd1);

    // EPOCH=0: START then END back to back
    epoch16 = 16'd0;
    push(C_S, 1); push(C_E, 1);
    run(1'b0, 1'b0, 20);
    check("t2_start_end_gap", 32'(end_cyc - start_cyc), 32'd1);
    check("t2_epoch_cnt", 32'(epc16), 32'd0);

    // No training, 2 validation samples, 2 epochs; accumulator cleared each epoch
    train16 = 16'd0; valid16 = 16'd2; epoch16 = 16'd2; mask = 16'b01;
    push(C_S, 1);
    push(C_V, 2); push(C_W, 1);
    push(C_V, 2); push(C_W, 1);
    push(C_E, 1);
    run(1'b0, 1'b0, 200);
    check("t3_epoch_cnt", 32'(epc16), 32'd2);
    check("t3_val_correct", 32'(valc16), 32'd1);

    // Reset while waiting on a training sample
    train16 = 16'd3; valid16 = 16'd2; epoch16 = 16'd1; mask = 16'b10;
    push(C_S, 1); push(C_T, 1);
    sel4 = 1'b0; saw_end = 1'b0;
    go16 = 1'b1;
    tick();
    go16 = 1'b0;
    for (int i = 0; i < 10 && last_obs != C_T; i++) tick();
    check("t4_reached_tiss", 32'(last_obs), 32'(C_T));
    tick();
    #1 rst = 1'b1;
    #1;
    check("t4_async_busy", 32'(busy16), 32'd0);
    check("t4_async_strobes", 32'({en16, sw16, vl16, tr16, st16}), 32'd0);
    check("t4_async_epoch", 32'(epc16), 32'd0);
    check("t4_async_valc", 32'(valc16), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    cd = 0;
    arch_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("t4_no_end", 32'(saw_end), 32'd0);
    push(C_S, 1); push(C_T, 3); push(C_V, 2); push(C_W, 1); push(C_E, 1);
    run(1'b0, 1'b0, 200);
    check("t4_restart_valc", 32'(valc16), 32'd1);
    check("t4_restart_epoch", 32'(epc16), 32'd1);

    // go held for the whole run, spurious arch_done in IDLE and T_ISS
    train16 = 16'd2; valid16 = 16'd1; epoch16 = 16'd1; mask = 16'b01;
    arch_done = 1'b1;
    tick();
    tick();
    spur_tiss = 1'b1;
    push(C_S, 1); push(C_T, 2); push(C_V, 1); push(C_W, 1); push(C_E, 1);
    run(1'b0, 1'b1, 200);
    spur_tiss = 1'b0;
    repeat (6) tick();
    check("t5_idle_after", 32'(busy16), 32'd0);
    check("t5_val_correct", 32'(valc16), 32'd1);
    check("t5_epoch_cnt", 32'(epc16), 32'd1);

    // 4-bit instance: 15 validation samples all correct reach full scale
    train4 = 4'd0; valid4 = 4'd15; epoch4 = 4'd1; mask = 16'hFFFF;
    push(C_S, 1); push(C_V, 15); push(C_W, 1); push(C_E, 1);
    run(1'b1, 1'b0, 300);
    check("t6_val_correct", 32'(valc4), 32'd15);
    check("t6_epoch_cnt", 32'(epc4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning the width of the count inputs and counter outputs.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-004 SHALL have port go, input, 1 bit, meaning a run request, honoured only in IDLE.
REQ-005 SHALL have ports TRAIN, VALID and EPOCH, inputs, BITS each, meaning the training-sample, validation-sample and epoch counts from the pattern block.
REQ-006 SHALL have port arch_done, input, 1 bit, meaning a one-cycle pulse from the architecture block when the current sample has been processed.
REQ-007 SHALL have port arch_correct, input, 1 bit, meaning the prediction matched the label; qualified by arch_done.
REQ-008 SHALL have ports START, TR, VL, SW and END, outputs, 1 bit each, meaning the control strobes to the pattern block.
REQ-009 SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE.
REQ-010 SHALL have port epoch_cnt, output, BITS, meaning the number of epochs completed in the current run.
REQ-011 SHALL have port val_correct, output, BITS, meaning the correct-prediction count of the last completed validation pass.

Function
REQ-012 SHALL implement the FSM states IDLE, STRT, T_ISS, T_WAIT, V_ISS, V_WAIT, STORE and FIN.
REQ-013 SHALL move IDLE->STRT in the cycle after go=1 is sampled; go outside IDLE SHALL be ignored.
REQ-014 SHALL assert START for exactly the one cycle spent in STRT, and SHALL clear the sample counter, the epoch counter and the correct-prediction accumulator in that cycle.
REQ-015 SHALL leave STRT to FIN when EPOCH==0; otherwise to T_ISS when TRAIN!=0; otherwise to V_ISS when VALID!=0; otherwise to STORE.
REQ-016 SHALL assert TR for exactly one cycle in T_ISS, increment the sample counter, and then go to T_WAIT.
REQ-017 SHALL hold T_WAIT until arch_done=1; it SHALL then go to T_ISS when sample_cnt<TRAIN, else clear sample_cnt and go to V_ISS (VALID!=0) or STORE (VALID==0).
REQ-018 SHALL assert VL for exactly one cycle in V_ISS, increment the sample counter, and then go to V_WAIT.
REQ-019 SHALL, in V_WAIT, add 1 to the correct-prediction accumulator when arch_done and arch_correct are both 1; on arch_done it SHALL go to V_ISS when sample_cnt<VALID, else clear sample_cnt and go to STORE.
REQ-020 SHALL assert SW for exactly one cycle in STORE, copy the accumulator to val_correct, clear the accumulator, and increment epoch_cnt.
REQ-021 SHALL leave STORE to FIN when the incremented epoch_cnt==EPOCH; otherwise to T_ISS (TRAIN!=0), V_ISS (VALID!=0) or STORE.
REQ-022 SHALL assert END for exactly one cycle in FIN and then return to IDLE; epoch_cnt and val_correct SHALL hold until the next STRT.
REQ-023 SHALL ignore arch_done in every state except T_WAIT and V_WAIT, and SHALL never assert more than one of START, TR, VL, SW and END in the same cycle.
REQ-024 SHALL sample TRAIN, VALID and EPOCH live; they SHALL be stable while busy=1 (integration rule, no internal latch).
REQ-025 SHALL size all counters at BITS width; the accumulator SHALL saturate at 2^BITS-1 and never wrap.
REQ-026 SHALL drive all outputs from registers, so strobes appear in the cycle after the state transition decision.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, all strobes=0, busy=0, epoch_cnt=0, val_correct=0, and sample_cnt and the accumulator to 0, immediately and regardless of clk.
REQ-028 SHALL, on rst asserted mid-run, abandon the run without asserting END, and resume only on a new go.

Structure
REQ-029 SHALL place the state enum type and the strobe-index constants in a shared package, nn_pkg.
REQ-030 SHALL consist of a single module with no sub-modules; the counters SHALL be inline.

Verification
REQ-031 SHALL cover: TRAIN=3, VALID=2, EPOCH=1, arch_done 2 cycles after each strobe, arch_correct=1 on 1 validation sample -> order START, TR x3, VL x2, SW, END; val_correct=1; epoch_cnt=1.
REQ-032 SHALL cover: EPOCH=0, go -> START then END on consecutive cycles; no TR, VL or SW.
REQ-033 SHALL cover: TRAIN=0, VALID=2, EPOCH=2 -> per epoch VL x2 then SW; final epoch_cnt=2; zero TR pulses.
REQ-034 SHALL cover: rst pulsed while in T_WAIT -> all outputs 0 asynchronously, no END; a later go restarts cleanly with START.
REQ-035 SHALL cover: go held high for the entire run, plus spurious arch_done pulses in IDLE and T_ISS -> exactly one run; no extra TR pulses.
REQ-036 SHALL cover: BITS=4, VALID=15, all samples correct, EPOCH=1 -> val_correct=15 with no wrap.
